// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
// Holds the FSM state enum, the cycle-type codes and the rotating-priority pick function.
package wb_arb_pkg;

    localparam int MAX_MASTERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // First requester at or above ptr, wrapping at n; result is one-hot or zero.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input int unsigned            ptr,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        int unsigned            idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[4:0]]) begin
                gnt[idx[4:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_sel.sv
// Combinational rotating-priority picker: request vector plus pointer in, one-hot grant out.
// Shared with the interconnect for other contended slaves.
module wb_rr_arbiter_sel
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] gnt_ext;
    logic [31:0]            ptr_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        ptr_ext         = '0;
        ptr_ext[PW-1:0] = ptr;
    end

    assign gnt_ext = rr_pick(req_ext, ptr_ext, N);
    assign gnt     = gnt_ext[N-1:0];
    // Bits above N are never set, so OR-ing the whole vector is exact.
    assign valid   = |gnt_ext;

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter, round-robin, ownership held for the whole cyc.
// Define WB_RR_ARBITER_TIMEOUT_EN to add the stb-to-response watchdog and ABORT state.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [AW*NUM_MASTERS-1:0]   wbm_adr_i,
    input  logic [DW*NUM_MASTERS-1:0]   wbm_dat_i,
    input  logic [DW/8*NUM_MASTERS-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]    wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]    wbm_bte_i,
    output logic [DW*NUM_MASTERS-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int SW = DW / 8;
    localparam int PW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("wb_rr_arbiter: NUM_MASTERS and TIMEOUT must both be >= 2");
    end

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant, pick;
    logic                   pick_vld;
    logic [PW-1:0]          ptr, own_idx, pick_idx, ptr_next;
    logic                   own_cyc, own_stb, route_en, to_hit, abort_err;

    wb_rr_arbiter_sel #(.N(NUM_MASTERS), .PW(PW)) u_sel (
        .req   (wbm_cyc_i),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    assign ptr_next = (own_idx == PW'(NUM_MASTERS - 1)) ? '0 : own_idx + 1'b1;

    // grant is one-hot or zero, so an AND-OR mux selects the owner's slice.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            own_cyc   |= wbm_cyc_i[i] & grant[i];
            own_stb   |= wbm_stb_i[i] & grant[i];
            wbs_adr_o |= wbm_adr_i[AW*i +: AW] & {AW{grant[i]}};
            wbs_dat_o |= wbm_dat_i[DW*i +: DW] & {DW{grant[i]}};
            wbs_sel_o |= wbm_sel_i[SW*i +: SW] & {SW{grant[i]}};
            wbs_we_o  |= wbm_we_i[i] & grant[i];
            wbs_cti_o |= wbm_cti_i[3*i +: 3] & {3{grant[i]}};
            wbs_bte_o |= wbm_bte_i[2*i +: 2] & {2{grant[i]}};
        end
    end

    // Slave traffic only flows while the owner still holds cyc.
    assign route_en = (state == OWN) & own_cyc;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          resp;

    assign resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign to_hit    = route_en & own_stb & ~resp & (cnt == CW'(TIMEOUT));
    assign abort_err = (state == ABORT) & own_cyc & own_stb;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !route_en || !own_stb || resp || to_hit) cnt <= '0;
        else                                                    cnt <= cnt + 1'b1;
    end
`else
    assign to_hit    = 1'b0;
    assign abort_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            own_idx <= '0;
        end else begin
            unique case (state)
                IDLE: if (pick_vld) begin
                    state   <= OWN;
                    grant   <= pick;
                    own_idx <= pick_idx;
                end
                OWN: if (!own_cyc) begin
                    state <= IDLE;
                    grant <= '0;
                    ptr   <= ptr_next;
                end else if (to_hit) begin
                    state <= ABORT;
                end
                ABORT: if (!own_cyc) begin
                    state <= IDLE;
                    grant <= '0;
                    ptr   <= ptr_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wbs_cyc_o = route_en;
    assign wbs_stb_o = route_en & own_stb;
    assign wbm_ack_o = grant & {NUM_MASTERS{route_en & wbs_ack_i}};
    assign wbm_rty_o = grant & {NUM_MASTERS{route_en & wbs_rty_i}};
    assign wbm_err_o = grant & {NUM_MASTERS{(route_en & wbs_err_i) | to_hit | abort_err}};
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign grant_o   = grant;
    assign timeout_o = to_hit;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized traffic against
// an owner/pointer reference model.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m_adr [N];
    logic [DW-1:0] m_dat [N];
    logic [2:0]    m_cti [N];
    logic          m_cyc [N];
    logic          m_stb [N];
    logic          m_we  [N];

    logic [AW*N-1:0]   wbm_adr_i;
    logic [DW*N-1:0]   wbm_dat_i;
    logic [DW/8*N-1:0] wbm_sel_i;
    logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [3*N-1:0]    wbm_cti_i;
    logic [2*N-1:0]    wbm_bte_i;
    logic [DW*N-1:0]   wbm_dat_o;
    logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic              wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
    logic [2:0]        wbs_cti_o;
    logic [1:0]        wbs_bte_o;
    logic [DW-1:0]     s_dat = '0;
    logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    int checks = 0;
    int errors = 0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            wbm_adr_i[AW*k +: AW] = m_adr[k];
            wbm_dat_i[DW*k +: DW] = m_dat[k];
            wbm_sel_i[4*k +: 4]   = 4'hF;
            wbm_cti_i[3*k +: 3]   = m_cti[k];
            wbm_bte_i[2*k +: 2]   = 2'b00;
            wbm_cyc_i[k]          = m_cyc[k];
            wbm_stb_i[k]          = m_stb[k];
            wbm_we_i[k]           = m_we[k];
        end
    end

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
            m_cti[k] = CTI_CLASSIC;
            m_adr[k] = 32'h1000_0000 + 32'(k) * 32'h100;
            m_dat[k] = 32'hA000_0000 + 32'(k);
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic req(input int k, input logic on);
        m_cyc[k] = on; m_stb[k] = on;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        req(0, 1'b1);
        s_ack = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0 || wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: grant=%b cyc=%b stb=%b, need 0000/0/0", grant_o, wbs_cyc_o, wbs_stb_o);
        end
        checks++;
        if (wbm_ack_o !== 4'b0 || wbm_err_o !== 4'b0 || wbm_rty_o !== 4'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: ack=%b err=%b rty=%b to=%b, need all 0", wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o);
        end
        step();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_single_read();
        do_reset();
        req(1, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0 || wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: grant=%b cyc=%b, need 0000/0", grant_o, wbs_cyc_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0010 || wbs_cyc_o !== 1'b1 || wbs_adr_o !== m_adr[1]) begin
            errors++;
            $display("FAIL single_grant: grant=%b cyc=%b adr=%h, need 0010/1/%h", grant_o, wbs_cyc_o, wbs_adr_o, m_adr[1]);
        end
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (wbm_ack_o !== 4'b0010 || wbm_dat_o[63:32] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_ack: ack=%b dat1=%h, need 0010/deadbeef", wbm_ack_o, wbm_dat_o[63:32]);
        end
        step();
        s_ack = 1'b0; req(1, 1'b0);
        @(negedge clk);
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbm_ack_o !== 4'b0) begin
            errors++;
            $display("FAIL single_release: cyc=%b ack=%b, need 0/0000", wbs_cyc_o, wbm_ack_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0) begin
            errors++;
            $display("FAIL single_idle: grant=%b, need 0000", grant_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int seen = 0, zero_run = 0;
        logic [N-1:0] prev = '0;
        logic acked[N];
        logic rearm[N];
        do_reset();
        for (int k = 0; k < N; k++) begin
            req(k, 1'b1); acked[k] = 1'b0; rearm[k] = 1'b0;
        end
        for (int cyc_i = 0; cyc_i < 80 && seen < 5; cyc_i++) begin
            @(negedge clk);
            if (grant_o === 4'b0) zero_run++;
            else if (grant_o !== prev) begin
                checks++;
                if (grant_o !== 4'(1 << exp_seq[seen]) || zero_run != 1) begin
                    errors++;
                    $display("FAIL rr_order: owner#%0d grant=%b gap=%0d, need %b gap=1", seen, grant_o, zero_run, 4'(1 << exp_seq[seen]));
                end
                seen++;
                zero_run = 0;
            end
            prev = grant_o;
            if (wbs_stb_o === 1'b1) begin
                s_ack = 1'b1;
                for (int k = 0; k < N; k++) if (grant_o[k]) acked[k] = 1'b1;
            end
            step();
            s_ack = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (acked[k]) begin req(k, 1'b0); acked[k] = 1'b0; rearm[k] = 1'b1; end
                else if (rearm[k]) begin req(k, 1'b1); rearm[k] = 1'b0; end
            end
        end
        checks++;
        if (seen != 5) begin
            errors++;
            $display("FAIL rr_timeout: saw %0d owners, need 5", seen);
        end
        idle_all();
        step(); step();
    endtask

    task automatic test_burst_hold();
        do_reset();
        req(0, 1'b1); req(1, 1'b1);
        m_cti[0] = CTI_INCR;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            step();
            s_ack = 1'b0;
            m_cti[0] = (b == 7) ? CTI_EOB : CTI_INCR;
            m_adr[0] = 32'h2000_0000 + 32'(b) * 4;
            @(negedge clk);
            checks++;
            if (grant_o !== 4'b0001 || wbs_adr_o !== m_adr[0] || wbs_cti_o !== m_cti[0]) begin
                errors++;
                $display("FAIL burst_hold: beat %0d grant=%b adr=%h cti=%b, need 0001/%h/%b", b, grant_o, wbs_adr_o, wbs_cti_o, m_adr[0], m_cti[0]);
            end
            s_ack = 1'b1;
        end
        step();
        s_ack = 1'b0; req(0, 1'b0);
        @(negedge clk);
        checks++;
        if (wbs_cyc_o !== 1'b0 || grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL burst_drop: cyc=%b grant=%b, need 0/0001", wbs_cyc_o, grant_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0) begin
            errors++;
            $display("FAIL burst_gap: grant=%b, need 0000", grant_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0010 || wbs_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_next: grant=%b cyc=%b, need 0010/1", grant_o, wbs_cyc_o);
        end
        idle_all();
        step(); step();
    endtask

    task automatic test_early_drop();
        do_reset();
        req(2, 1'b1);
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0100 || wbs_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_grant: grant=%b cyc=%b, need 0100/1", grant_o, wbs_cyc_o);
        end
        step();
        req(2, 1'b0);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbm_ack_o !== 4'b0) begin
            errors++;
            $display("FAIL drop_same_cycle: cyc=%b stb=%b ack=%b, need 0/0/0000", wbs_cyc_o, wbs_stb_o, wbm_ack_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0 || wbm_ack_o !== 4'b0) begin
            errors++;
            $display("FAIL drop_late_ack: grant=%b ack=%b, need 0000/0000", grant_o, wbm_ack_o);
        end
        idle_all();
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req(2, 1'b1); m_cti[2] = CTI_INCR;
        step();
        @(negedge clk);
        s_ack = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; s_ack = 1'b0;
        req(2, 1'b0); req(1, 1'b1); req(3, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0 || wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: grant=%b cyc=%b, need 0000/0", grant_o, wbs_cyc_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_ptr: grant=%b, need 0010", grant_o);
        end
        idle_all();
        step(); step();
    endtask

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req(3, 1'b1);
        step();
        for (int t = 0; t < TO; t++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== 4'b1000 || wbm_err_o !== 4'b0 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL to_early: t=%0d grant=%b err=%b to=%b, need 1000/0000/0", t, grant_o, wbm_err_o, timeout_o);
            end
            step();
            if (t == 0) req(0, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (wbm_err_o !== 4'b1000 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_fire: err=%b to=%b, need 1000/1", wbm_err_o, timeout_o);
        end
        step();
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0 || timeout_o !== 1'b0 || wbm_err_o !== 4'b1000 || wbm_ack_o !== 4'b0) begin
            errors++;
            $display("FAIL to_abort: cyc=%b to=%b err=%b ack=%b, need 0/0/1000/0000", wbs_cyc_o, timeout_o, wbm_err_o, wbm_ack_o);
        end
        step();
        s_ack = 1'b0; req(3, 1'b0);
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0) begin
            errors++;
            $display("FAIL to_release: grant=%b, need 0000", grant_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL to_next: grant=%b, need 0001", grant_o);
        end
        idle_all();
        step(); step();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req(3, 1'b1);
        step();
        for (int t = 0; t < 3 * TO; t++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== 4'b1000 || wbs_cyc_o !== 1'b1 || wbm_err_o !== 4'b0 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL hang_hold: t=%0d grant=%b cyc=%b err=%b to=%b, need 1000/1/0000/0", t, grant_o, wbs_cyc_o, wbm_err_o, timeout_o);
            end
            step();
        end
        idle_all();
        step(); step();
    endtask
`endif

    task automatic test_random();
        int owner = -1, ptr = 0, stall = 0, nxt;
        int waits[N];
        logic acked[N];
        logic [N-1:0] exp_g, exp_ack;
        logic exp_cyc;
        do_reset();
        for (int k = 0; k < N; k++) begin waits[k] = 0; acked[k] = 1'b0; end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp_g   = (owner < 0) ? 4'b0 : 4'(1 << owner);
            exp_cyc = (owner >= 0) && m_cyc[owner];
            checks++;
            if (grant_o !== exp_g || wbs_cyc_o !== exp_cyc) begin
                errors++;
                $display("FAIL rand_grant: c=%0d grant=%b cyc=%b, need %b/%b", c, grant_o, wbs_cyc_o, exp_g, exp_cyc);
            end
            s_ack = 1'b0;
            if (exp_cyc) begin
                checks++;
                if (wbs_adr_o !== m_adr[owner] || wbs_dat_o !== m_dat[owner] || wbs_we_o !== m_we[owner]) begin
                    errors++;
                    $display("FAIL rand_mux: c=%0d adr=%h dat=%h we=%b, need %h/%h/%b", c, wbs_adr_o, wbs_dat_o, wbs_we_o, m_adr[owner], m_dat[owner], m_we[owner]);
                end
                s_ack = (stall >= 3) || ($urandom_range(1, 0) == 1);
                stall = s_ack ? 0 : stall + 1;
                s_dat = $urandom;
                if (s_ack) acked[owner] = 1'b1;
            end
            #1;
            exp_ack = (s_ack && exp_cyc) ? 4'(1 << owner) : 4'b0;
            checks++;
            if (wbm_ack_o !== exp_ack || (exp_cyc && wbm_dat_o[DW*owner +: DW] !== s_dat)) begin
                errors++;
                $display("FAIL rand_ack: c=%0d ack=%b, need %b", c, wbm_ack_o, exp_ack);
            end
            @(posedge clk);
            // Reference: owner/pointer move according to the cyc values sampled at this edge.
            if (owner < 0) begin
                nxt = -1;
                for (int i = 0; i < N; i++)
                    if (nxt < 0 && m_cyc[(ptr + i) % N]) nxt = (ptr + i) % N;
                if (nxt >= 0) begin
                    for (int k = 0; k < N; k++) if (k != nxt && m_cyc[k]) waits[k]++;
                    checks++;
                    if (waits[nxt] > N - 1) begin
                        errors++;
                        $display("FAIL rand_starve: m%0d waited %0d owners, need <= %0d", nxt, waits[nxt], N - 1);
                    end
                    waits[nxt] = 0;
                    stall = 0;
                end
                owner = nxt;
            end else if (!m_cyc[owner]) begin
                ptr = (owner + 1) % N;
                owner = -1;
            end
            #1;
            s_ack = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (acked[k]) begin
                    req(k, 1'b0); acked[k] = 1'b0;
                end else if (m_cyc[k] && owner == k && $urandom_range(15, 0) == 0) begin
                    req(k, 1'b0);
                end else if (!m_cyc[k] && $urandom_range(2, 0) == 0) begin
                    req(k, 1'b1);
                    m_adr[k] = $urandom; m_dat[k] = $urandom; m_we[k] = 1'($urandom);
                end
            end
        end
        idle_all();
        step(); step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_hold();
        test_early_drop();
        test_reset_mid_burst();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone B3 arbiter with rotating (round-robin) priority and burst-aware ownership.
- Used in the multi-core interconnect in front of shared slaves (main RAM, UART), so all core I/D ports plus the debug master share one slave port fairly.
- Replaces fixed-priority arbitration, which starves high-index cores; adds an optional bus watchdog.

Parameters:
NUM_MASTERS, 2, number of master ports (>=2)
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT, 255, watchdog cycles from stb to response before abort (>=2; used only with macro)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbm_adr_i  in  AW*NUM_MASTERS  master addresses, master k at [AW*(k+1)-1:AW*k]
wbm_dat_i  in  DW*NUM_MASTERS  master write data
wbm_sel_i  in  (DW/8)*NUM_MASTERS  byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_cyc_i  in  NUM_MASTERS  cycle (bus request)
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cti_i  in  3*NUM_MASTERS  cycle type
wbm_bte_i  in  2*NUM_MASTERS  burst type
wbm_dat_o  out  DW*NUM_MASTERS  read data, broadcast to all slices
wbm_ack_o  out  NUM_MASTERS  ack, granted master only
wbm_err_o  out  NUM_MASTERS  err, granted master only
wbm_rty_o  out  NUM_MASTERS  rty, granted master only
wbs_adr_o / wbs_dat_o / wbs_sel_o / wbs_we_o / wbs_cti_o / wbs_bte_o  out  AW/DW/DW/8/1/3/2  muxed from granted master
wbs_cyc_o  out  1  granted master cyc, gated by ownership
wbs_stb_o  out  1  granted master stb, gated by ownership
wbs_dat_i / wbs_ack_i / wbs_err_i / wbs_rty_i  in  DW/1/1/1  slave response
grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values:
  - FSM enters IDLE; grant_o=0.
  - Priority pointer = master 0 (highest priority is master 0 on the first arbitration).
  - wbs_cyc_o=0, wbs_stb_o=0; all wbm ack/err/rty=0; timeout_o=0.
  - Reset mid-transfer drops ownership in the same edge.
- FSM states: IDLE, OWN, ABORT (ABORT exists only with the macro).
- IDLE:
  - If any wbm_cyc_i is set, select the first requester searching upward from pointer, wrapping NUM_MASTERS-1 to 0.
  - Register its one-hot grant and go to OWN.
  - Grant latency: 1 cycle from cyc to grant; slave sees cyc/stb in the cycle after the request.
- OWN:
  - Slave outputs are combinationally muxed from the owner; wbs_cyc_o=owner cyc, wbs_stb_o=owner stb.
  - Slave ack/err/rty are routed combinationally to the owner only.
  - Ownership is held for the whole cyc, including incrementing bursts (cti 010) and multiple stb's; no preemption.
- Release:
  - Owner cyc=0 in OWN -> next state IDLE, grant_o=0.
  - Pointer becomes (owner+1) mod NUM_MASTERS.
  - Gives exactly one dead cycle between owners.
- Simultaneous requests: resolved by the pointer only; a master holding cyc continuously is served within NUM_MASTERS-1 foreign ownerships.
- Master drops cyc mid-burst: treated as normal release; slave cyc drops the same cycle.
- Slave response while IDLE: ignored (not forwarded).
- wbm_dat_o: every slice carries wbs_dat_i; masters qualify with their own ack.

Optional Feature:
WB_RR_ARBITER_TIMEOUT_EN
- With the macro:
  - In OWN, a counter clears on any ack/err/rty or when owner stb=0, and increments while owner stb=1 with no response.
  - When the counter reaches TIMEOUT, the owner gets err_o=1 for that cycle, timeout_o pulses, and the FSM goes to ABORT.
- ABORT:
  - wbs_cyc_o=wbs_stb_o=0 and slave responses are discarded.
  - Each owner stb cycle receives err_o=1 combinationally.
  - Owner cyc=0 -> IDLE, with the pointer advanced.
- Without the macro: no counter, no ABORT state, timeout_o tied 0; a hung slave hangs the owner.

Decomposition:
- Shared package wb_arb_pkg:
  - FSM state enum (IDLE/OWN/ABORT);
  - CTI constants (CLASSIC=000, INCR=010, EOB=111);
  - function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, wb_rr_arbiter_sel: combinational rotating-priority picker (req vector, pointer -> one-hot grant, valid). Reused by the intercon for other shared slaves.

Test Plan:
- Reset then m1 cyc=1 alone -> grant_o=0b10 one cycle later; single read, slave ack with dat=0xDEADBEEF -> wbm_ack_o=0b10, slice 1 read data 0xDEADBEEF; m0 ack stays 0.
- NUM_MASTERS=4, all cyc=1 continuously, each cyc lasting one classic transfer -> grant order 0,1,2,3,0 with one idle cycle between owners.
- m0 does an 8-beat incrementing burst (cti 010..111) while m1 requests -> m1 not granted until m0 drops cyc; then grant_o=0b10 after one idle cycle.
- Owner drops cyc before ack -> wbs_cyc_o=0 the same cycle; a late slave ack is not forwarded to any master.
- Macro on, TIMEOUT=8, slave never acks -> err to owner and timeout_o pulse exactly 8 cycles after stb; wbs_cyc_o=0 until owner releases; next requester granted afterwards.
- Reset asserted mid-burst -> next cycle grant_o=0 and wbs_cyc_o=0; pointer returns to 0.
